// File: rtl/spi_gpio_expander.sv
// SPI-slave GPIO expander: banked output latches, direction control and input
// readback over MISO, with auto-incrementing burst access. SPI is oversampled.
module spi_gpio_expander #(
  parameter int unsigned g_num_banks = 2,
  parameter logic [6:0]  g_dev_addr  = 7'h20
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic                     spi_sclk_i,
  input  logic                     spi_cs_n_i,
  input  logic                     spi_mosi_i,
  output logic                     spi_miso_o,
  input  logic [8*g_num_banks-1:0] gpio_i,
  output logic [8*g_num_banks-1:0] gpio_o,
  output logic [8*g_num_banks-1:0] gpio_oe_o,
  output logic                     wr_strobe_o,
  output logic                     frame_err_o
);

  localparam int unsigned W = 8 * g_num_banks;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } state_t;

  logic [1:0]   sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic         sclk_prev_q, cs_prev_q;
  logic         sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q, mosi_q;
  logic [W-1:0] gpio_meta_q, gpio_sync_q;

  state_t       state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [1:0]   nbytes_q, nbytes_d;
  logic [6:0]   sh_q, sh_d;
  logic [7:0]   ptr_q, ptr_d;
  logic         rd_q, rd_d;
  logic [7:0]   tx_q, tx_d;
  logic         miso_q, miso_d;
  logic [W-1:0] olat_q, olat_d;
  logic [W-1:0] iodir_q, iodir_d;
  logic         wr_strobe_q, wr_strobe_d;
  logic         frame_err_q, frame_err_d;

  logic [7:0]   byte_in;
  logic         byte_done;
  logic [7:0]   rd_addr;
  logic [3:0]   rd_idx, wr_idx;
  logic [7:0]   rd_data;

  // cs_n sync chain resets low so a frame already in progress at reset release
  // produces no falling edge; only a later genuine cs_n fall starts a frame.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      mosi_q      <= 1'b0;
      gpio_meta_q <= '0;
      gpio_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
      sclk_rise_q <= sclk_sync_q[1] & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_sync_q[1] & sclk_prev_q;
      cs_rise_q   <= cs_sync_q[1] & ~cs_prev_q;
      cs_fall_q   <= ~cs_sync_q[1] & cs_prev_q;
      mosi_q      <= mosi_sync_q[1];
      gpio_meta_q <= gpio_i;
      gpio_sync_q <= gpio_meta_q;
    end
  end

  assign byte_in   = {sh_q, mosi_q};
  assign byte_done = sclk_rise_q && (bit_cnt_q == 3'd7);

  always_comb begin
    rd_addr = (state_q == S_ADDR) ? byte_in : ptr_q + 8'd1;
    rd_idx  = rd_addr[3:0];
    rd_data = '0;
    if ({28'd0, rd_idx} < g_num_banks) begin
      case (rd_addr[7:4])
        4'h0:    rd_data = olat_q[8*rd_idx +: 8];
        4'h1:    rd_data = iodir_q[8*rd_idx +: 8];
        4'h2:    rd_data = gpio_sync_q[8*rd_idx +: 8];
        default: rd_data = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    nbytes_d    = nbytes_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    rd_d        = rd_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    olat_d      = olat_q;
    iodir_d     = iodir_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    wr_idx      = ptr_q[3:0];

    if (cs_rise_q) begin
      // cs_n rise outranks a coincident sclk edge: that bit is dropped.
      frame_err_d = (state_q != S_IDLE) &&
                    ((bit_cnt_q != 3'd0) || (nbytes_q == 2'd1) || (nbytes_q == 2'd2));
      state_d     = S_IDLE;
      miso_d      = 1'b0;
    end else if (cs_fall_q) begin
      state_d   = S_OPCODE;
      bit_cnt_d = '0;
      nbytes_d  = '0;
      rd_d      = 1'b0;
      tx_d      = '0;
      miso_d    = 1'b0;
    end else if (sclk_rise_q && (state_q != S_IDLE)) begin
      sh_d      = {sh_q[5:0], mosi_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (byte_done) begin
        if (nbytes_q != 2'd3) nbytes_d = nbytes_q + 2'd1;
        case (state_q)
          S_OPCODE: begin
            if (sh_q == g_dev_addr) begin
              state_d = S_ADDR;
              rd_d    = mosi_q;
            end else begin
              state_d = S_IGNORE;
            end
          end
          S_ADDR: begin
            ptr_d   = byte_in;
            state_d = S_DATA;
            if (rd_q) tx_d = rd_data;
          end
          S_DATA: begin
            if (!rd_q && ({28'd0, wr_idx} < g_num_banks)) begin
              if (ptr_q[7:4] == 4'h0) begin
                olat_d[8*wr_idx +: 8] = byte_in;
                wr_strobe_d           = 1'b1;
              end else if (ptr_q[7:4] == 4'h1) begin
                iodir_d[8*wr_idx +: 8] = byte_in;
                wr_strobe_d            = 1'b1;
              end
            end
            if (rd_q) tx_d = rd_data;
            ptr_d = ptr_q + 8'd1;
          end
          default: ;
        endcase
      end
    end else if (sclk_fall_q) begin
      if ((state_q == S_DATA) && rd_q) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end else begin
        miso_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      nbytes_q    <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      rd_q        <= 1'b0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      olat_q      <= '0;
      iodir_q     <= '1;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      nbytes_q    <= nbytes_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      rd_q        <= rd_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      olat_q      <= olat_d;
      iodir_q     <= iodir_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_miso_o  = miso_q;
  assign gpio_o      = olat_q;
  assign gpio_oe_o   = ~iodir_q;
  assign wr_strobe_o = wr_strobe_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_gpio_expander.sv
// Bench for spi_gpio_expander: directed and random SPI frames compared against
// a register-map reference model.
module tb_spi_gpio_expander;

  localparam int unsigned NB = 2;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out, gpio_oe;
  logic         wr_strobe, frame_err;

  spi_gpio_expander #(.g_num_banks(NB), .g_dev_addr(7'h20)) dut (
    .clk_sys_i  (clk),
    .rst_n_i    (rst_n),
    .spi_sclk_i (sclk),
    .spi_cs_n_i (cs_n),
    .spi_mosi_i (mosi),
    .spi_miso_o (miso),
    .gpio_i     (gpio_in),
    .gpio_o     (gpio_out),
    .gpio_oe_o  (gpio_oe),
    .wr_strobe_o(wr_strobe),
    .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int ferrs = 0;

  always @(posedge clk) begin
    if (wr_strobe) strobes++;
    if (frame_err) ferrs++;
  end

  logic [7:0] m_olat [NB];
  logic [7:0] m_iodir[NB];
  logic [7:0] fb     [0:7];
  logic [7:0] rx     [0:7];
  logic [7:0] exp_rx [0:7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < NB; k++) begin
      m_olat[k]  = 8'h00;
      m_iodir[k] = 8'hFF;
    end
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int idx = int'(a[3:0]);
    if (idx >= NB) return 8'h00;
    case (a[7:4])
      4'h0:    return m_olat[idx];
      4'h1:    return m_iodir[idx];
      4'h2:    return gpio_in[8*idx +: 8];
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit m_write(input logic [7:0] a, input logic [7:0] d);
    int idx = int'(a[3:0]);
    if (idx >= NB) return 1'b0;
    if (a[7:4] == 4'h0) begin m_olat[idx] = d;  return 1'b1; end
    if (a[7:4] == 4'h1) begin m_iodir[idx] = d; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] m_gpio();
    logic [W-1:0] v;
    for (int k = 0; k < NB; k++) v[8*k +: 8] = m_olat[k];
    return v;
  endfunction

  function automatic logic [W-1:0] m_oe();
    logic [W-1:0] v;
    for (int k = 0; k < NB; k++) v[8*k +: 8] = ~m_iodir[k];
    return v;
  endfunction

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    repeat (8) @(posedge clk);
    #1 sclk = 1'b1;
    m = miso;
    repeat (8) @(posedge clk);
    #1 sclk = 1'b0;
  endtask

  // Sends nfull bytes from fb, then `extra` leading bits of fb[nfull].
  task automatic run_frame(input int nfull, input int extra, input string tag);
    int         s0, e0, exp_s, nb;
    logic [7:0] ptr;
    logic       m;
    exp_s = 0;
    for (int j = 0; j < 8; j++) begin
      exp_rx[j] = 8'h00;
      rx[j]     = 8'h00;
    end
    if (nfull >= 2 && fb[0][7:1] == 7'h20) begin
      ptr = fb[1];
      for (int j = 2; j < nfull; j++) begin
        if (fb[0][0]) exp_rx[j] = m_read(ptr);
        else if (m_write(ptr, fb[j])) exp_s++;
        ptr = ptr + 8'd1;
      end
    end
    s0 = strobes;
    e0 = ferrs;
    cs_n = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int b = 0; b <= nfull; b++) begin
      nb = (b < nfull) ? 8 : extra;
      for (int i = 0; i < nb; i++) begin
        spi_bit(fb[b][7-i], m);
        rx[b][7-i] = m;
      end
    end
    repeat (8) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check({tag, ".gpio_o"}, 32'(gpio_out), 32'(m_gpio()));
    check({tag, ".gpio_oe"}, 32'(gpio_oe), 32'(m_oe()));
    check({tag, ".strobes"}, 32'(strobes - s0), 32'(exp_s));
    check({tag, ".frame_err"}, 32'(ferrs - e0),
          32'((extra != 0 || (nfull >= 1 && nfull <= 2)) ? 1 : 0));
    check({tag, ".miso_idle"}, 32'(miso), 32'd0);
    for (int b = 0; b < nfull; b++)
      check($sformatf("%s.rx%0d", tag, b), 32'(rx[b]), 32'(exp_rx[b]));
  endtask

  logic [7:0] atab [12] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h11,
                            8'h12, 8'h20, 8'h21, 8'h22, 8'hFE, 8'hFF};

  initial begin
    int   nfull, extra, e0;
    logic m;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.gpio_o", 32'(gpio_out), 32'd0);
    check("rst.gpio_oe", 32'(gpio_oe), 32'd0);
    check("rst.miso", 32'(miso), 32'd0);
    check("rst.strobe", 32'(wr_strobe), 32'd0);
    check("rst.ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    fb[0] = 8'h40; fb[1] = 8'h00; fb[2] = 8'hA5;
    run_frame(3, 0, "wr_olat0");
    check("wr_olat0.value", 32'(gpio_out[7:0]), 32'hA5);

    fb[0] = 8'h40; fb[1] = 8'h10; fb[2] = 8'h0F; fb[3] = 8'hF0;
    run_frame(4, 0, "wr_iodir");
    check("wr_iodir.oe", 32'(gpio_oe), 32'h0FF0);

    gpio_in = 16'h3C5A;
    fb[0] = 8'h41; fb[1] = 8'h20; fb[2] = 8'h00; fb[3] = 8'h00;
    run_frame(4, 0, "rd_input");
    check("rd_input.lo", 32'(rx[2]), 32'h5A);
    check("rd_input.hi", 32'(rx[3]), 32'h3C);

    fb[0] = 8'h42; fb[1] = 8'h00; fb[2] = 8'hFF;
    run_frame(3, 0, "wrong_dev");

    fb[0] = 8'h40; fb[1] = 8'h00; fb[2] = 8'hFF;
    run_frame(2, 5, "short");

    fb[0] = 8'h40; fb[1] = 8'hFF; fb[2] = 8'h11; fb[3] = 8'h22;
    run_frame(4, 0, "wrap");

    fb[0] = 8'h41; fb[1] = 8'h10; fb[2] = 8'h00; fb[3] = 8'h00; fb[4] = 8'h00;
    run_frame(5, 0, "rd_burst");

    fb[0] = 8'h40; fb[1] = 8'h00; fb[2] = 8'hA5;
    run_frame(3, 0, "pre_rst");

    // Reset asserted while sclk is high on the 20th bit of a write frame.
    fb[0] = 8'h40; fb[1] = 8'h01; fb[2] = 8'hC3;
    e0 = ferrs;
    cs_n = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 19; i++) spi_bit(fb[i/8][7-(i%8)], m);
    mosi = fb[2][4];
    repeat (8) @(posedge clk);
    #1 sclk = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check("midrst.gpio_o", 32'(gpio_out), 32'd0);
    check("midrst.gpio_oe", 32'(gpio_oe), 32'd0);
    check("midrst.miso", 32'(miso), 32'd0);
    repeat (3) @(posedge clk);
    #1 sclk = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
    repeat (8) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst.after_gpio", 32'(gpio_out), 32'd0);
    check("midrst.after_ferr", 32'(ferrs - e0), 32'd0);

    fb[0] = 8'h40; fb[1] = 8'h01; fb[2] = 8'h77;
    run_frame(3, 0, "post_rst");

    for (int it = 0; it < 30; it++) begin
      gpio_in = W'($urandom);
      fb[0] = {($urandom_range(0, 7) == 0) ? 7'h21 : 7'h20, 1'($urandom_range(0, 1))};
      fb[1] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : atab[$urandom_range(0, 11)];
      for (int j = 2; j < 8; j++) fb[j] = 8'($urandom);
      nfull = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 6);
      extra = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(nfull, extra, $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
